// File: rtl/barrel_multiplier_u2.sv
// Pipelined signed multiply-by-2^shift_n (arithmetic left log-shifter) with
// per-result overflow flag, optional saturation, valid/ready flow control and a
// sticky overflow counter.
module barrel_multiplier_u2 #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = $clog2(WIDTH),
  parameter bit          SAT     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] shift_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf,
  output logic [7:0]         ovf_count,
  input  logic               ovf_clr
);

  localparam int unsigned LAST = SHIFT_W - 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_multiplier_u2: WIDTH must be a power of two and at least 4");
  end

  // Stage registers; shift and sign are only needed by the stages that follow.
  logic [WIDTH-1:0]   val_q  [SHIFT_W];
  logic [SHIFT_W-1:0] sh_q   [LAST];
  logic [LAST-1:0]    sign_q;
  logic [SHIFT_W-1:0] ovf_q;
  logic [SHIFT_W-1:0] vld_q;

  // Per-stage inputs and next values.
  logic [WIDTH-1:0]   src_val  [SHIFT_W];
  logic [SHIFT_W-1:0] src_sh   [SHIFT_W];
  logic [SHIFT_W-1:0] src_sign;
  logic [SHIFT_W-1:0] src_ovf;
  logic [SHIFT_W-1:0] src_vld;
  logic [WIDTH-1:0]   nxt_val  [SHIFT_W];
  logic [SHIFT_W-1:0] nxt_sh   [LAST];
  logic [LAST-1:0]    nxt_sign;
  logic [SHIFT_W-1:0] nxt_ovf;
  logic               en;

  assign en       = !vld_q[LAST] || out_ready;
  assign in_ready = en;

  assign src_val[0]  = in_data;
  assign src_sh[0]   = shift_n;
  assign src_sign[0] = in_data[WIDTH-1];
  assign src_ovf[0]  = 1'b0;
  assign src_vld[0]  = in_valid;

  for (genvar k = 1; k < SHIFT_W; k++) begin : g_src
    assign src_val[k]  = val_q[k-1];
    assign src_sh[k]   = sh_q[k-1];
    assign src_sign[k] = sign_q[k-1];
    assign src_ovf[k]  = ovf_q[k-1];
    assign src_vld[k]  = vld_q[k-1];
  end

  // Each stage consumes the LSB of the remaining shift amount.
  for (genvar k = 0; k < LAST; k++) begin : g_fwd
    assign nxt_sh[k]   = src_sh[k] >> 1;
    assign nxt_sign[k] = src_sign[k];
  end

  // Stage k shifts by 2^k; the top 2^k+1 bits must agree or the value overflows.
  always_comb begin
    logic [WIDTH-1:0] top;
    top     = '0;
    nxt_val = '{default: '0};
    nxt_ovf = '0;
    for (int k = 0; k < int'(SHIFT_W); k++) begin
      top        = WIDTH'($signed(src_val[k]) >>> (int'(WIDTH) - 1 - (1 << k)));
      nxt_ovf[k] = src_ovf[k] | (src_sh[k][0] & ~((top == '0) | (top == '1)));
      nxt_val[k] = src_sh[k][0] ? (src_val[k] << (1 << k)) : src_val[k];
      if (SAT && k == int'(LAST) && nxt_ovf[k]) begin
        nxt_val[k] = src_sign[k] ? MIN_NEG : MAX_POS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      sh_q   <= '{default: '0};
      sign_q <= '0;
      ovf_q  <= '0;
      vld_q  <= '0;
    end else if (en) begin
      val_q  <= nxt_val;
      sh_q   <= nxt_sh;
      sign_q <= nxt_sign;
      ovf_q  <= nxt_ovf;
      vld_q  <= src_vld;
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_data  = val_q[LAST];
  assign out_ovf   = ovf_q[LAST];

  // Sticky count of delivered overflowed results; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && ovf_count != 8'hFF) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule
